// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, recode selects
// and the default operand width.
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Q,
    ADD,
    SHIFT,
    OUT_HI,
    OUT_LO
  } state_e;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_PM,
    PP_P2M,
    PP_NM,
    PP_N2M
  } pp_e;

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth recoder: picks the WIDTH+2-bit addend (0, +-M, +-2M) and
// carry-in from {Q[1:0], Q_1}. Negation is invert plus carry-in.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       bits,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] addend,
  output logic             cin
);

  pp_e              pp;
  logic [WIDTH+1:0] m_ext;

  assign m_ext = {{2{m[WIDTH-1]}}, m};

  always_comb begin
    pp = PP_ZERO;
    case (bits)
      3'b001, 3'b010: pp = PP_PM;
      3'b011:         pp = PP_P2M;
      3'b100:         pp = PP_N2M;
      3'b101, 3'b110: pp = PP_NM;
      default:        pp = PP_ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (pp)
      PP_PM:  addend = m_ext;
      PP_P2M: addend = {m_ext[WIDTH:0], 1'b0};
      PP_NM: begin
        addend = ~m_ext;
        cin    = 1'b1;
      end
      PP_N2M: begin
        addend = ~{m_ext[WIDTH:0], 1'b0};
        cin    = 1'b1;
      end
      default: begin
        addend = '0;
        cin    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/parallel_adder.sv
// Plain WIDTH-bit adder with carry-in; carry-out is discarded.
module parallel_adder #(
  parameter int unsigned WIDTH = 18
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b + {{(WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/booth_mul.sv
// Sequential signed radix-4 Booth multiplier on a word-serial bus.
// Optional overflow flag output enabled by defining BOOTH_MUL_OVF_EN.
module booth_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] inbus,
  output logic             busy,
  output logic             out_valid,
  output logic             out_lo,
`ifdef BOOTH_MUL_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] outbus
);

  localparam int unsigned CNT_W = (WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH/2 - 1);

  state_e           state, state_next;
  logic [WIDTH-1:0] m, q;
  logic [WIDTH+1:0] a;
  logic             q_1;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] addend, sum, a_sh;
  logic [WIDTH-1:0] q_sh;
  logic             cin;

  booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
    .bits   ({q[1:0], q_1}),
    .m      (m),
    .addend (addend),
    .cin    (cin)
  );

  parallel_adder #(.WIDTH(WIDTH+2)) u_adder (
    .a   (a),
    .b   (addend),
    .cin (cin),
    .sum (sum)
  );

  assign a_sh = {{2{a[WIDTH+1]}}, a[WIDTH+1:2]};
  assign q_sh = {a[1:0], q[WIDTH-1:2]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_Q;
      LOAD_Q:  state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = (cnt == CNT_LAST) ? OUT_HI : ADD;
      OUT_HI:  state_next = OUT_LO;
      OUT_LO:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m   <= '0;
      q   <= '0;
      a   <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) m <= inbus;
        LOAD_Q: begin
          q   <= inbus;
          a   <= '0;
          q_1 <= 1'b0;
          cnt <= '0;
        end
        ADD: a <= sum;
        SHIFT: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[1];
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from state_next so they line up with OUT_HI/OUT_LO;
  // the high word comes from the final shift result as it is being written.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_lo    <= 1'b0;
      outbus    <= '0;
    end else begin
      busy      <= (state_next != IDLE);
      out_valid <= (state_next == OUT_HI) || (state_next == OUT_LO);
      out_lo    <= (state_next == OUT_LO);
      if (state_next == OUT_HI)      outbus <= a_sh[WIDTH-1:0];
      else if (state_next == OUT_LO) outbus <= q;
      else                           outbus <= '0;
    end
  end

`ifdef BOOTH_MUL_OVF_EN
  logic [WIDTH:0] p_top;
  assign p_top = {a_sh[WIDTH-1:0], q_sh[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                    ovf <= 1'b0;
    else if (state_next == OUT_HI) ovf <= !((&p_top) || !(|p_top));
    else if (state_next == IDLE)   ovf <= 1'b0;
  end
`endif

endmodule

// File: doc/booth_mul.md
Name: booth_mul

Overview:
- Sequential signed multiplier using radix-4 Booth recoding. It is the inverse companion of the team's non-restoring divider.
- Shares the same 16-bit word-serial bus protocol: load the multiplicand word, then the multiplier word; the block iterates; it then returns the 32-bit product as a high word followed by a low word on outbus.
- Sits in the ALU datapath next to the divider and is driven by the same sequencer.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4. Product is 2*WIDTH. Iteration count is WIDTH/2.

Ports:
- clk  input  1  clock, rising-edge.
- rst_b  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- inbus  input  WIDTH  operand word (multiplicand on the start cycle, multiplier on the next cycle).
- busy  output  1  high from LOAD_Q through OUT_LO.
- out_valid  output  1  outbus carries a product word.
- out_lo  output  1  0 = high word, 1 = low word; meaningful only with out_valid.
- outbus  output  WIDTH  product word; 0 when out_valid = 0.

Behaviour:
- Reset (async, rst_b = 0): state IDLE. M, Q, A, Q_1 and counter cleared. busy, out_valid, out_lo = 0; outbus = 0.
- Registers:
  - M: WIDTH bits.
  - A: WIDTH+2 bits, signed, so it can hold ±2M when M = most-negative.
  - Q: WIDTH bits.
  - Q_1: 1 bit.
  - cnt: log2(WIDTH/2) bits.
- State machine: IDLE -> LOAD_Q -> ADD -> SHIFT -> (ADD ... SHIFT) x WIDTH/2 -> OUT_HI -> OUT_LO -> IDLE.
- IDLE: on an edge with start = 1, M <= inbus and go to LOAD_Q. start = 0 stays in IDLE.
- LOAD_Q: Q <= inbus, A <= 0, Q_1 <= 0, cnt <= 0. Go to ADD.
- ADD: recode {Q[1], Q[0], Q_1}:
  - 000/111 -> A unchanged.
  - 001/010 -> A + M.
  - 011 -> A + 2M.
  - 100 -> A - 2M.
  - 101/110 -> A - M.
  - M is sign-extended to WIDTH+2 bits. Subtraction is done as invert plus carry-in.
- SHIFT: arithmetic right shift of {A, Q, Q_1} by 2. cnt <= cnt + 1. If cnt == WIDTH/2 - 1 before the increment, go to OUT_HI; otherwise go to ADD.
- Product = {A[WIDTH-1:0], Q} after the last SHIFT.
- OUT_HI: out_valid = 1, out_lo = 0, outbus = A[WIDTH-1:0].
- OUT_LO: out_valid = 1, out_lo = 1, outbus = Q. Then return to IDLE.
- Outputs are registered and decoded from the state register. No combinational path from inbus or start to any output.
- Latency: with start sampled at edge k, OUT_HI is the cycle after edge k+1+WIDTH. For WIDTH = 16 that is 18 cycles; OUT_LO follows one cycle later.
- start while busy: ignored, no queueing.
- start asserted in OUT_LO: ignored; the next request needs start in IDLE.
- Reset mid-operation: immediate return to the IDLE reset values; the partial result is discarded.
- Boundaries:
  - 0x8000 x 0x8000 must give 0x4000_0000 (the 2M path requires the extra A bits).
  - Either operand 0 gives 0 after the full iteration count. There is no early exit.

Optional Feature:
- Macro BOOTH_MUL_OVF_EN.
- Defined: adds output port ovf (1 bit), registered. It is valid with out_valid and is high when the product is not representable in WIDTH signed bits, i.e. product[2*WIDTH-1:WIDTH-1] is not all-equal. Reset value 0; cleared in IDLE.
- Undefined: the port is absent and no overflow logic is generated.

Decomposition:
- Shared package mul_pkg holds:
  - the state enum (IDLE, LOAD_Q, ADD, SHIFT, OUT_HI, OUT_LO);
  - the Booth recode enum (PP_ZERO, PP_PM, PP_P2M, PP_NM, PP_N2M);
  - the default WIDTH constant.
- One natural sub-module, booth_pp_sel: purely combinational. It takes {Q[1:0], Q_1} and M and produces the WIDTH+2-bit addend plus carry-in.
- The add itself reuses the team's parallel_adder at WIDTH+2 width.

Test Plan:
- 7 x 3 -> OUT_HI outbus 0x0000, then OUT_LO 0x0015; out_valid high exactly 2 cycles, 18 cycles after start.
- -5 (0xFFFB) x 3 -> 0xFFFF then 0xFFF1; with BOOTH_MUL_OVF_EN, ovf = 0.
- 0x8000 x 0x8000 -> 0x4000 then 0x0000; ovf = 1.
- 0x7FFF x 0x8000 -> 0xC000 then 0x8000.
- start pulsed during ADD/SHIFT with inbus = 0x1234 -> ignored; the in-flight result is unchanged and busy profile unchanged.
- rst_b low for 1 ns at SHIFT #4 -> all outputs 0 immediately, state IDLE; a new 2 x 2 request then returns 0x0000 then 0x0004.
